cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Refill sequencer for the I/D cache miss path. On a tag miss it issues one critical-word-first wrapping burst to memory, then tracks the returning beats. For the response reorder stage directly downstream it produces:
- the beat index (`rsp_burst_cnt`),
- the one-hot critical-block select (`offset_mux_sel`),
- the early-restart strobes (`burst_pre_go_on`, `burst_pre_rsp_vld`),
- the end-of-burst pulse (`rsp_burst_done_neg`).

It also signals line-fill completion to the array write logic.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `DW`, 64, memory beat width; beats are 8-byte aligned
- `OFFSET_DW`, 5, line byte-offset width
- `BLOCK_DW`, 4, beats per line (= 2^(OFFSET_DW-3))
- `BURST_DW`, 2, beat counter width (log2 BLOCK_DW)

Ports:
- `clk` in 1: single clock; all state on rising edge
- `rstn` in 1: asynchronous, active-low reset
- `miss_req_vld` in 1: miss request
- `miss_req_rdy` out 1: controller can accept a miss
- `miss_addr` in ADDR_W: missing byte address
- `miss_read` in 1: miss caused by a read (early restart allowed)
- `cache2mem_cmd_valid` out 1: burst command valid
- `cache2mem_cmd_ready` in 1: memory accepts command
- `cache2mem_cmd_addr` out ADDR_W: critical doubleword address
- `cache2mem_cmd_len` out BURST_DW: beats-1, constant BLOCK_DW-1
- `cache2mem_rsp_valid` in 1: response beat valid (no backpressure)
- `cache2mem_rsp_err` in 1: beat error, qualified by rsp_valid
- `rsp_burst_cnt` out BURST_DW: index of the beat currently on the response bus
- `offset_mux_sel` out BLOCK_DW: one-hot critical block
- `burst_pre_go_on` out 1: critical beat now resident in line buffer
- `burst_pre_rsp_vld` out 1: early-restart data valid to core
- `rsp_burst_done_neg` out 1: one-cycle pulse after last beat
- `refill_done` out 1: line complete, error-free; write array
- `refill_err` out 1: line complete with ≥1 beat error
- `busy` out 1: state ≠ IDLE or early-restart strobe pending

## Operation
- States: IDLE, CMD, DATA, DONE.
- IDLE:
  - `miss_req_rdy` = 1, except in the cycle `burst_pre_rsp_vld` is high.
  - On `miss_req_vld & miss_req_rdy`:
    - latch address and `miss_read`;
    - crit = `miss_addr[OFFSET_DW-1:3]`;
    - `offset_mux_sel` <= 1<<crit;
    - clear the error flag;
    - go to CMD.
- CMD:
  - `cache2mem_cmd_valid` = 1.
  - `cache2mem_cmd_addr` = {latched `addr[ADDR_W-1:3]`, 3'b0}, held stable until ready.
  - On ready: `rsp_burst_cnt` <= 0, go to DATA.
- DATA:
  - Each `cache2mem_rsp_valid` is beat `rsp_burst_cnt`. The error flag ORs in `cache2mem_rsp_err`.
  - When cnt = BLOCK_DW-1, go to DONE. Otherwise cnt+1.
  - Cnt never wraps inside a burst.
- DONE (one cycle):
  - `rsp_burst_done_neg` = 1.
  - `refill_done` = !err, `refill_err` = err.
  - Go to IDLE. `offset_mux_sel` holds until the next accepted miss.
- Response valid outside DATA is ignored: no counter, flag or output change.
- Error beats are still counted. Early restart fires even if beat 0 errored; the core learns of the error via `refill_err`.
- `burst_pre_go_on` and `burst_pre_rsp_vld` are only ever asserted for a read miss (`miss_read` = 1).

## Timing
- Reset values:
  - all outputs 0, except `miss_req_rdy` = 1;
  - `offset_mux_sel` = 0, `rsp_burst_cnt` = 0;
  - state = IDLE.
- Minimum miss→first command: 1 cycle (request accepted in cycle T, `cmd_valid` in T+1).
- Beat 0 at T0 → `burst_pre_go_on` at T0+1 (early restart) → `burst_pre_rsp_vld` at T0+2. Each strobe is a single-cycle pulse.
- Last beat at TL → DONE at TL+1 (`rsp_burst_done_neg`, `refill_done`/`refill_err`) → IDLE at TL+2.
- Back-to-back beats are supported at one per cycle. Gaps of any length are allowed.
- If `burst_pre_go_on` and DONE coincide (BLOCK_DW=1 or a late strobe), both are asserted in the same cycle.
- Reset mid-burst returns to IDLE immediately. Beats arriving after reset are ignored.

## Configuration
- `CACHE_REFILL_EARLY_RESTART_EN` defined:
  - `burst_pre_go_on` pulses the cycle after beat 0, i.e. at T0+1.
  - `burst_pre_rsp_vld` follows one cycle later, while the rest of the burst continues.
- Not defined:
  - `burst_pre_go_on` pulses in the DONE cycle.
  - `burst_pre_rsp_vld` pulses the following cycle (state IDLE, `busy` = 1, `miss_req_rdy` = 0).
  - Critical word latency = full-line latency + 1.

## Test plan
- **Read miss, addr 0x0000_1018, beats contiguous, early restart on:** cmd_addr 0x0000_1018; offset_mux_sel 4'b1000; rsp_burst_cnt 0,1,2,3; pre_go_on at T0+1; pre_rsp_vld at T0+2; done_neg and refill_done at TL+1.
- **Same miss, macro off:** pre_go_on coincides with done_neg; pre_rsp_vld one cycle later; a miss_req_vld held high is accepted only on the cycle after that.
- **Write miss (miss_read=0), addr 0x40:** offset_mux_sel 4'b0001; pre_go_on and pre_rsp_vld never assert; refill_done pulses once.
- **cmd_ready held low 5 cycles, beats with 3-cycle gaps, err on beat 2:** cmd_addr stable throughout; refill_err=1 and refill_done=0 in DONE.
- **Spurious rsp_valid in IDLE and CMD; rstn dropped after beat 1:** no counter or output change on the spurious beats; all outputs at reset values; next miss starts cleanly with cnt 0.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Refill sequencer for the I/D cache miss path. A miss issues one
//   critical-word-first wrapping burst, then the returning beats are tracked.
//   For the downstream reorder stage it produces:
//     - the beat index,
//     - the one-hot critical block select,
//     - the early-restart strobes,
//     - the end-of-burst pulse.
//   It also signals line-fill completion to the array write logic.
//
//   Optional feature macro: CACHE_REFILL_EARLY_RESTART_EN
//     defined   : burst_pre_go_on fires the cycle after beat 0.
//     undefined : burst_pre_go_on fires in the DONE cycle, so the critical
//                 word is released only after the whole line has arrived.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   miss_req_vld/_rdy            miss request handshake
//   miss_addr, miss_read         missing byte address, read-miss flag
//   cache2mem_cmd_*              burst command (valid/ready, addr, len)
//   cache2mem_rsp_valid/_err     response beats (no backpressure)
//   rsp_burst_cnt                index of the beat on the response bus
//   offset_mux_sel               one-hot critical block
//   burst_pre_go_on              critical beat resident in line buffer
//   burst_pre_rsp_vld            early-restart data valid to core
//   rsp_burst_done_neg           one-cycle pulse after the last beat
//   refill_done / refill_err     line complete, clean / with error
//   busy                         controller not idle or strobe pending
module cache_refill_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DW        = 64,
  parameter int OFFSET_DW = 5,
  parameter int BLOCK_DW  = 4,
  parameter int BURST_DW  = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                miss_req_vld,
  output logic                miss_req_rdy,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic                miss_read,
  output logic                cache2mem_cmd_valid,
  input  logic                cache2mem_cmd_ready,
  output logic [ADDR_W-1:0]   cache2mem_cmd_addr,
  output logic [BURST_DW-1:0] cache2mem_cmd_len,
  input  logic                cache2mem_rsp_valid,
  input  logic                cache2mem_rsp_err,
  output logic [BURST_DW-1:0] rsp_burst_cnt,
  output logic [BLOCK_DW-1:0] offset_mux_sel,
  output logic                burst_pre_go_on,
  output logic                burst_pre_rsp_vld,
  output logic                rsp_burst_done_neg,
  output logic                refill_done,
  output logic                refill_err,
  output logic                busy
);

  localparam int                  BEAT_LSB  = $clog2(DW / 8);
  localparam logic [BURST_DW-1:0] LAST_BEAT = BURST_DW'(BLOCK_DW - 1);
  localparam logic [ADDR_W-1:0]   BEAT_MASK = ADDR_W'(DW / 8 - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                read_q, read_d;
  logic [BLOCK_DW-1:0] sel_q, sel_d;
  logic [BURST_DW-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                go_q, go_d;
  logic                pvld_q, pvld_d;
  logic [BURST_DW-1:0] crit;
  logic                go_beat;

  assign crit = miss_addr[OFFSET_DW-1:BEAT_LSB];

  // Which beat releases the critical word to the core.
`ifdef CACHE_REFILL_EARLY_RESTART_EN
  assign go_beat = (cnt_q == '0);
`else
  assign go_beat = (cnt_q == LAST_BEAT);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      read_q  <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
      pvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      go_q    <= go_d;
      pvld_q  <= pvld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    read_d  = read_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    go_d    = 1'b0;
    // Data-valid strobe always trails the go-on strobe by one cycle.
    pvld_d  = go_q;
    unique case (state_q)
      IDLE: begin
        if (miss_req_vld && miss_req_rdy) begin
          addr_d  = miss_addr;
          read_d  = miss_read;
          sel_d   = BLOCK_DW'(1) << crit;
          err_d   = 1'b0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (cache2mem_cmd_ready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cache2mem_rsp_valid) begin
          err_d = err_q | cache2mem_rsp_err;
          go_d  = read_q & go_beat;
          // Counter parks on the last beat rather than wrapping.
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + BURST_DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pending data-valid strobe blocks a new miss for that one cycle.
  assign miss_req_rdy        = (state_q == IDLE) && !pvld_q;
  assign cache2mem_cmd_valid = (state_q == CMD);
  assign cache2mem_cmd_addr  = addr_q & ~BEAT_MASK;
  assign cache2mem_cmd_len   = LAST_BEAT;
  assign rsp_burst_cnt       = cnt_q;
  assign offset_mux_sel      = sel_q;
  assign burst_pre_go_on     = go_q;
  assign burst_pre_rsp_vld   = pvld_q;
  assign rsp_burst_done_neg  = (state_q == DONE);
  assign refill_done         = (state_q == DONE) && !err_q;
  assign refill_err          = (state_q == DONE) && err_q;
  assign busy                = (state_q != IDLE) || go_q || pvld_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

`ifdef CACHE_REFILL_EARLY_RESTART_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        miss_req_vld;
  logic        miss_req_rdy;
  logic [31:0] miss_addr;
  logic        miss_read;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_err;
  logic [1:0]  rsp_cnt;
  logic [3:0]  sel;
  logic        pre_go;
  logic        pre_vld;
  logic        done_neg;
  logic        refill_done;
  logic        refill_err;
  logic        busy;

  cache_refill_ctrl dut (
    .clk                 (clk),
    .rstn                (rstn),
    .miss_req_vld        (miss_req_vld),
    .miss_req_rdy        (miss_req_rdy),
    .miss_addr           (miss_addr),
    .miss_read           (miss_read),
    .cache2mem_cmd_valid (cmd_valid),
    .cache2mem_cmd_ready (cmd_ready),
    .cache2mem_cmd_addr  (cmd_addr),
    .cache2mem_cmd_len   (cmd_len),
    .cache2mem_rsp_valid (rsp_valid),
    .cache2mem_rsp_err   (rsp_err),
    .rsp_burst_cnt       (rsp_cnt),
    .offset_mux_sel      (sel),
    .burst_pre_go_on     (pre_go),
    .burst_pre_rsp_vld   (pre_vld),
    .rsp_burst_done_neg  (done_neg),
    .refill_done         (refill_done),
    .refill_err          (refill_err),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a transaction is "waiting for command" (1) or
  // "collecting beats" (2); strobes and the completion cycle are scheduled
  // as absolute cycle numbers when the triggering beat is seen.
  int          phase   = 0;
  int          beats   = 0;
  int          cnt_m   = 0;
  int          go_at   = -10;
  int          vld_at  = -10;
  int          done_at = -10;
  logic [31:0] addr_m  = '0;
  logic [3:0]  sel_m   = '0;
  bit          read_m  = 1'b0;
  bit          err_m   = 1'b0;

  always @(posedge clk) begin : model_blk
    int c;
    int e;
    c   = cyc;
    e   = c + 1;
    cyc = e;
    if (!rstn) begin
      phase = 0; beats = 0; cnt_m = 0;
      go_at = -10; vld_at = -10; done_at = -10;
      addr_m = '0; sel_m = '0; read_m = 1'b0; err_m = 1'b0;
    end else if (phase == 2) begin
      if (rsp_valid) begin
        err_m = err_m | rsp_err;
        if (beats == 0 && read_m && EARLY) begin
          go_at = e; vld_at = e + 1;
        end
        if (beats == 3) begin
          phase   = 0;
          done_at = e;
          if (read_m && !EARLY) begin
            go_at = e; vld_at = e + 1;
          end
        end else begin
          beats = beats + 1;
        end
        cnt_m = beats;
      end
    end else if (phase == 1) begin
      if (cmd_ready) begin
        phase = 2; beats = 0; cnt_m = 0;
      end
    end else if (miss_req_vld && c != done_at && c != vld_at) begin
      phase  = 1;
      addr_m = miss_addr;
      read_m = miss_read;
      sel_m  = 4'b0001 << miss_addr[4:3];
      err_m  = 1'b0;
    end
  end

  // Observed-event log used by the directed literal checks.
  int go_last = -1, vld_last = -1, done_last = -1;
  int go_cnt = 0, vld_cnt = 0, done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin : cmp_blk
    int   c;
    bit   act;
    logic [31:0] e_rdy, e_cv, e_addr, e_cnt, e_sel, e_go, e_vld, e_dn, e_rd, e_re, e_busy;
    c = cyc;
    if (!rstn) begin
      e_rdy = 1; e_cv = 0; e_addr = 0; e_cnt = 0; e_sel = 0; e_go = 0;
      e_vld = 0; e_dn = 0; e_rd = 0; e_re = 0; e_busy = 0;
    end else begin
      act    = (phase == 1) || (phase == 2) || (c == done_at);
      e_rdy  = 32'(!act && (c != vld_at));
      e_cv   = 32'(phase == 1);
      e_addr = {addr_m[31:3], 3'b000};
      e_cnt  = 32'(cnt_m);
      e_sel  = 32'(sel_m);
      e_go   = 32'(c == go_at);
      e_vld  = 32'(c == vld_at);
      e_dn   = 32'(c == done_at);
      e_rd   = 32'((c == done_at) && !err_m);
      e_re   = 32'((c == done_at) && err_m);
      e_busy = 32'(act || (c == go_at) || (c == vld_at));
    end
    chk("miss_req_rdy",   32'(miss_req_rdy), e_rdy);
    chk("cmd_valid",      32'(cmd_valid),    e_cv);
    chk("cmd_addr",       cmd_addr,          e_addr);
    chk("cmd_len",        32'(cmd_len),      32'd3);
    chk("rsp_burst_cnt",  32'(rsp_cnt),      e_cnt);
    chk("offset_mux_sel", 32'(sel),          e_sel);
    chk("pre_go_on",      32'(pre_go),       e_go);
    chk("pre_rsp_vld",    32'(pre_vld),      e_vld);
    chk("done_neg",       32'(done_neg),     e_dn);
    chk("refill_done",    32'(refill_done),  e_rd);
    chk("refill_err",     32'(refill_err),   e_re);
    chk("busy",           32'(busy),         e_busy);
    if (pre_go)      begin go_last = c;   go_cnt++;   end
    if (pre_vld)     begin vld_last = c;  vld_cnt++;  end
    if (done_neg)    done_last = c;
    if (refill_done) done_cnt++;
    if (refill_err)  err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic burst(input int gap);
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
      if (i < 3) repeat (gap) tick();
    end
  endtask

  int  t0, tl, cmdcyc, gc, vc, dc, ec;
  bit  got;

  initial begin
    rstn = 1'b0; miss_req_vld = 1'b0; miss_addr = '0; miss_read = 1'b0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
    repeat (3) tick();
    chk("reset_rdy", 32'(miss_req_rdy), 32'd1);
    chk("reset_cnt", 32'(rsp_cnt), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    rstn = 1'b1;
    tick();

    // Read miss at 0x1018, contiguous beats.
    miss_req_vld = 1'b1; miss_addr = 32'h0000_1018; miss_read = 1'b1;
    tick();
    miss_req_vld = 1'b0;
    chk("t1_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("t1_cmd_addr", cmd_addr, 32'h0000_1018);
    chk("t1_sel", 32'(sel), 32'h8);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1;
      chk("t1_cnt", 32'(rsp_cnt), 32'(i));
      tick();
    end
    rsp_valid = 1'b0;
    tl = t0 + 3;
    // Hold the next miss high from the DONE cycle on.
    miss_req_vld = 1'b1; miss_addr = 32'h0000_2008; miss_read = 1'b1;
    got = 1'b0; cmdcyc = -1;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (cmd_valid) begin got = 1'b1; cmdcyc = cyc; end
    end
    miss_req_vld = 1'b0;
    if (!got) begin n_vec++; n_fail++; $display("FAIL t2_accept_timeout: no cmd_valid within 10 cycles"); end
    chk("t2_accept_cyc", 32'(cmdcyc), EARLY ? 32'(tl + 3) : 32'(tl + 4));
    chk("t1_go_cyc",   32'(go_last),   EARLY ? 32'(t0 + 1) : 32'(tl + 1));
    chk("t1_vld_cyc",  32'(vld_last),  EARLY ? 32'(t0 + 2) : 32'(tl + 2));
    chk("t1_done_cyc", 32'(done_last), 32'(tl + 1));
    chk("t1_done_cnt", 32'(done_cnt),  32'd1);

    // Command stalled 5 cycles, gapped beats, error on beat 2.
    for (int k = 0; k < 5; k++) begin
      chk("t4_cmd_valid", 32'(cmd_valid), 32'd1);
      chk("t4_cmd_addr", cmd_addr, 32'h0000_2008);
      chk("t4_sel", 32'(sel), 32'h2);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    ec = err_cnt; dc = done_cnt;
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1; rsp_err = (i == 2);
      tick();
      rsp_valid = 1'b0; rsp_err = 1'b0;
      if (i < 3) repeat (3) tick();
    end
    repeat (4) tick();
    chk("t4_err_pulses",  32'(err_cnt - ec),  32'd1);
    chk("t4_done_pulses", 32'(done_cnt - dc), 32'd0);

    // Write miss at 0x40.
    gc = go_cnt; vc = vld_cnt; dc = done_cnt;
    miss_req_vld = 1'b1; miss_addr = 32'h0000_0040; miss_read = 1'b0;
    tick();
    miss_req_vld = 1'b0;
    chk("t3_sel", 32'(sel), 32'h1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    burst(0);
    repeat (4) tick();
    chk("t3_go_pulses",   32'(go_cnt - gc),   32'd0);
    chk("t3_vld_pulses",  32'(vld_cnt - vc),  32'd0);
    chk("t3_done_pulses", 32'(done_cnt - dc), 32'd1);

    // Spurious beats in IDLE and CMD, then reset mid-burst.
    rsp_valid = 1'b1;
    repeat (2) tick();
    chk("t5_idle_cnt", 32'(rsp_cnt), 32'd3);
    miss_req_vld = 1'b1; miss_addr = 32'h0000_1010; miss_read = 1'b1;
    tick();
    miss_req_vld = 1'b0;
    repeat (2) tick();
    chk("t5_cmd_cnt", 32'(rsp_cnt), 32'd3);
    rsp_valid = 1'b0; cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t5_data_cnt0", 32'(rsp_cnt), 32'd0);
    rsp_valid = 1'b1;
    repeat (2) tick();
    chk("t5_data_cnt2", 32'(rsp_cnt), 32'd2);
    rstn = 1'b0;
    #1;
    chk("t5_rst_rdy",  32'(miss_req_rdy), 32'd1);
    chk("t5_rst_cnt",  32'(rsp_cnt), 32'd0);
    chk("t5_rst_sel",  32'(sel), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    rsp_valid = 1'b0;
    chk("t5_post_cnt",  32'(rsp_cnt), 32'd0);
    chk("t5_post_busy", 32'(busy), 32'd0);
    miss_req_vld = 1'b1; miss_addr = 32'h0000_1000; miss_read = 1'b1;
    tick();
    miss_req_vld = 1'b0;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1;
      chk("t5_new_cnt", 32'(rsp_cnt), 32'(i));
      tick();
    end
    rsp_valid = 1'b0;
    repeat (4) tick();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rstn         = ($urandom_range(0, 199) != 0);
      miss_req_vld = $urandom_range(0, 2) == 0;
      miss_addr    = $urandom;
      miss_read    = $urandom_range(0, 1) == 1;
      cmd_ready    = $urandom_range(0, 2) != 0;
      rsp_valid    = $urandom_range(0, 1) == 1;
      rsp_err      = $urandom_range(0, 7) == 0;
      tick();
    end
    rstn = 1'b1; miss_req_vld = 1'b0; rsp_valid = 1'b0; cmd_ready = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
